// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM state encoding, NOP word, reset PC.
// No logic; imported by pc_fetch_unit and fetch_perf_counter.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Delivered-instruction and accepted-redirect counters, 32-bit wrapping.
// Latency: count visible the cycle after the event; no backpressure.
module fetch_perf_counter
   import pc_fetch_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_inc,
   input  logic        i_redirect_inc,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_redirect_cnt
);

   logic [31:0] r_fetch_cnt;
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_cnt    <= '0;
         r_redirect_cnt <= '0;
      end else begin
         if (i_fetch_inc)    r_fetch_cnt    <= r_fetch_cnt + 32'd1;
         if (i_redirect_inc) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
   end

   assign o_fetch_cnt    = r_fetch_cnt;
   assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, imem read handshake, registered INSTR_OUT/PC_OUT, redirect drain.
// Latency: one cycle from read completion to INSTR_VALID; STALL parks in HOLD, PC_SEL overrides it.
// FETCH_PERF_CNT_EN adds the fetch/redirect counters; otherwise the counter ports read 0.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        PC_SEL,
   input  logic [31:0] BRANCH_TARGET,
   input  logic        STALL,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic        IMEM_BUSYWAIT,
   input  logic [31:0] IMEM_INSTR,
   output logic [31:0] INSTR_OUT,
   output logic [31:0] PC_OUT,
   output logic [31:0] PC_PLUS4,
   output logic        INSTR_VALID,
   output logic        FLUSH_OUT,
   output logic [31:0] FETCH_CNT,
   output logic [31:0] REDIRECT_CNT
);

   fetch_state_t r_state;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  r_pending;
   logic [31:0]  r_instr;
   logic [31:0]  r_pc_out;
   logic         r_valid;
   logic         r_flush;

   logic         w_read;
   logic         w_done;
   logic [31:0]  w_target;

   // Read request drops immediately with reset so a half-finished access is abandoned.
   assign w_read   = RESET_N && (r_state != ST_HOLD);
   assign w_done   = w_read && !IMEM_BUSYWAIT;
   assign w_target = align_word(BRANCH_TARGET);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_FETCH;
         r_fetch_pc <= RESET_PC;
         r_pending  <= '0;
         r_instr    <= NOP_INSTR;
         r_pc_out   <= RESET_PC;
         r_valid    <= 1'b0;
         r_flush    <= 1'b0;
      end else begin
         r_flush <= PC_SEL;
         case (r_state)
            ST_FETCH: begin
               if (PC_SEL) begin
                  r_valid <= 1'b0;
                  r_instr <= NOP_INSTR;
                  if (w_done) begin
                     r_fetch_pc <= w_target;
                  end else begin
                     r_pending <= w_target;
                     r_state   <= ST_DRAIN;
                  end
               end else if (w_done) begin
                  if (r_valid && STALL) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_instr    <= IMEM_INSTR;
                     r_pc_out   <= r_fetch_pc;
                     r_valid    <= 1'b1;
                     r_fetch_pc <= r_fetch_pc + 32'd4;
                  end
               end else if (!STALL) begin
                  r_valid <= 1'b0;
                  r_instr <= NOP_INSTR;
               end
            end
            ST_HOLD: begin
               if (PC_SEL) begin
                  r_valid    <= 1'b0;
                  r_instr    <= NOP_INSTR;
                  r_fetch_pc <= w_target;
                  r_state    <= ST_FETCH;
               end else if (!STALL) begin
                  r_valid <= 1'b0;
                  r_instr <= NOP_INSTR;
                  r_state <= ST_FETCH;
               end
            end
            ST_DRAIN: begin
               // Output is already invalid here; only the redirect target can change.
               if (PC_SEL) r_pending <= w_target;
               if (w_done) begin
                  r_fetch_pc <= PC_SEL ? w_target : r_pending;
                  r_state    <= ST_FETCH;
               end
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   assign IMEM_ADDR   = r_fetch_pc;
   assign IMEM_READ   = w_read;
   assign INSTR_OUT   = r_instr;
   assign PC_OUT      = r_pc_out;
   assign PC_PLUS4    = r_pc_out + 32'd4;
   assign INSTR_VALID = r_valid;
   assign FLUSH_OUT   = r_flush;

`ifdef FETCH_PERF_CNT_EN
   logic w_deliver;

   assign w_deliver = (r_state == ST_FETCH) && !PC_SEL && w_done && !(r_valid && STALL);

   fetch_perf_counter u_perf (
      .i_clk          (CLK),
      .i_rst_n        (RESET_N),
      .i_fetch_inc    (w_deliver),
      .i_redirect_inc (PC_SEL),
      .o_fetch_cnt    (FETCH_CNT),
      .o_redirect_cnt (REDIRECT_CNT)
   );
`else
   assign FETCH_CNT    = '0;
   assign REDIRECT_CNT = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Fetch unit bench: directed scenarios then random PC_SEL/STALL/BUSYWAIT traffic against a cycle reference model.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        PC_SEL;
   logic [31:0] BRANCH_TARGET;
   logic        STALL;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic        IMEM_BUSYWAIT;
   logic [31:0] IMEM_INSTR;
   logic [31:0] INSTR_OUT;
   logic [31:0] PC_OUT;
   logic [31:0] PC_PLUS4;
   logic        INSTR_VALID;
   logic        FLUSH_OUT;
   logic [31:0] FETCH_CNT;
   logic [31:0] REDIRECT_CNT;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   logic [31:0] m_pc, m_pend, m_instr, m_pc_out, m_fcnt, m_rcnt;
   bit          m_valid, m_flush, m_hold, m_drain;

   always #5 CLK = ~CLK;

   pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .PC_SEL        (PC_SEL),
      .BRANCH_TARGET (BRANCH_TARGET),
      .STALL         (STALL),
      .IMEM_ADDR     (IMEM_ADDR),
      .IMEM_READ     (IMEM_READ),
      .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
      .IMEM_INSTR    (IMEM_INSTR),
      .INSTR_OUT     (INSTR_OUT),
      .PC_OUT        (PC_OUT),
      .PC_PLUS4      (PC_PLUS4),
      .INSTR_VALID   (INSTR_VALID),
      .FLUSH_OUT     (FLUSH_OUT),
      .FETCH_CNT     (FETCH_CNT),
      .REDIRECT_CNT  (REDIRECT_CNT)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_pend = '0; m_instr = NOP; m_pc_out = RST_PC;
      m_fcnt = '0; m_rcnt = '0;
      m_valid = 0; m_flush = 0; m_hold = 0; m_drain = 0;
   endtask

   task automatic check_all();
      logic [31:0] exp_f, exp_r;
`ifdef FETCH_PERF_CNT_EN
      exp_f = m_fcnt; exp_r = m_rcnt;
`else
      exp_f = '0; exp_r = '0;
`endif
      chk("imem_addr",    IMEM_ADDR,           m_pc);
      chk("imem_read",    32'(IMEM_READ),      32'(RESET_N && !m_hold));
      chk("instr_out",    INSTR_OUT,           m_valid ? m_instr : NOP);
      chk("pc_out",       PC_OUT,              m_pc_out);
      chk("pc_plus4",     PC_PLUS4,            m_pc_out + 32'd4);
      chk("instr_valid",  32'(INSTR_VALID),    32'(m_valid));
      chk("flush_out",    32'(FLUSH_OUT),      32'(m_flush));
      chk("fetch_cnt",    FETCH_CNT,           exp_f);
      chk("redirect_cnt", REDIRECT_CNT,        exp_r);
   endtask

   // Apply the rules for one rising edge using the inputs currently driven.
   task automatic model_step();
      logic [31:0] tgt;
      bit done;
      tgt  = BRANCH_TARGET & 32'hFFFF_FFFC;
      done = !m_hold && !IMEM_BUSYWAIT;
      if (m_drain) begin
         if (PC_SEL) m_pend = tgt;
         if (done) begin m_pc = m_pend; m_drain = 0; end
      end else if (m_hold) begin
         if (PC_SEL)      begin m_pc = tgt; m_valid = 0; m_hold = 0; end
         else if (!STALL) begin m_valid = 0; m_hold = 0; end
      end else begin
         if (PC_SEL) begin
            m_valid = 0;
            if (done) m_pc = tgt;
            else begin m_pend = tgt; m_drain = 1; end
         end else if (done) begin
            if (m_valid && STALL) m_hold = 1;
            else begin
               m_instr = IMEM_INSTR; m_pc_out = m_pc; m_valid = 1;
               m_pc = m_pc + 32'd4; m_fcnt = m_fcnt + 32'd1;
            end
         end else if (!STALL) m_valid = 0;
      end
      m_flush = PC_SEL;
      if (PC_SEL) m_rcnt = m_rcnt + 32'd1;
   endtask

   // One cycle: check outputs, drive inputs for the next edge, advance the model.
   task automatic step(input bit sel, input logic [31:0] tgt, input bit stl, input bit bsy);
      check_all();
      PC_SEL        = sel;
      BRANCH_TARGET = tgt;
      STALL         = stl;
      IMEM_BUSYWAIT = bsy;
      IMEM_INSTR    = bsy ? $urandom : mem_word(m_pc);
      model_step();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_reset_pulse();
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge CLK);
      check_all();
      RESET_N = 1'b1;
      #1;
   endtask

   initial begin
      RESET_N = 1'b0; PC_SEL = 0; BRANCH_TARGET = '0; STALL = 0;
      IMEM_BUSYWAIT = 0; IMEM_INSTR = '0;
      model_reset();
      @(negedge CLK);
      check_all();
      RESET_N = 1'b1;
      #1;

      // Sequential fetch, busy wait at 0x104, redirect while busy at 0x108.
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      step(1, 32'h200, 0, 1);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      // Deliver, then stall with a valid output held, release, then redirect+stall in HOLD.
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);
      step(1, 32'h203, 1, 0);
      step(0, 32'h0, 0, 0);
      // Redirect to the top of the address space to exercise wrap.
      step(1, 32'hFFFF_FFFE, 0, 0);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0);
      // Back-to-back redirects in DRAIN.
      step(1, 32'h300, 0, 1);
      step(1, 32'h401, 0, 1);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] t;
         if (i == 700) do_reset_pulse();
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         step($urandom_range(0, 11) == 0, t, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- PC_SEL  in  1  redirect request from the branch/jump detect stage.
- BRANCH_TARGET  in  32  redirect address, sampled when PC_SEL=1.
- STALL  in  1  downstream cannot accept INSTR_OUT this cycle.
- IMEM_ADDR  out  32  instruction memory address.
- IMEM_READ  out  1  instruction memory read request.
- IMEM_BUSYWAIT  in  1  memory busy; a read completes on a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_INSTR  in  32  read data, valid at completion.
- INSTR_OUT  out  32  registered fetched instruction.
- PC_OUT  out  32  registered address of INSTR_OUT.
- PC_PLUS4  out  32  PC_OUT+4, combinational.
- INSTR_VALID  out  1  INSTR_OUT holds a valid instruction.
- FLUSH_OUT  out  1  one-cycle pulse the cycle after a redirect is accepted.
- FETCH_CNT  out  32  delivered-instruction count (see Configuration).
- REDIRECT_CNT  out  32  accepted-redirect count (see Configuration).

Function
REQ-003 The block SHALL implement a three-state FSM: FETCH (read in flight), HOLD (output stalled, no read), DRAIN (discard an in-flight read after a redirect).
REQ-004 IMEM_READ SHALL be 1 in FETCH and DRAIN, 0 in HOLD, and 0 while RESET_N=0.
REQ-005 IMEM_ADDR SHALL stay equal to the fetch PC register, unchanged, until the read completes.
REQ-006 At completion in FETCH with PC_SEL=0, if !(INSTR_VALID && STALL): INSTR_OUT<=IMEM_INSTR, PC_OUT<=fetch PC, INSTR_VALID<=1, fetch PC<=fetch PC+4, state stays FETCH.
REQ-007 At completion in FETCH with INSTR_VALID=1, STALL=1 and PC_SEL=0: discard the data, leave the fetch PC unchanged, go to HOLD.
REQ-008 In FETCH with no completion: if STALL=0, INSTR_VALID<=0; if STALL=1, hold the outputs.
REQ-009 In HOLD: hold all outputs while STALL=1; when STALL=0, INSTR_VALID<=0 and go to FETCH.
REQ-010 PC_SEL SHALL take priority over STALL in every state.
REQ-011 PC_SEL in HOLD, or in FETCH at completion: INSTR_VALID<=0, fetch PC<={BRANCH_TARGET[31:2],2'b00}, next state FETCH.
REQ-012 PC_SEL in FETCH without completion: latch the aligned target into a pending register, INSTR_VALID<=0, go to DRAIN.
REQ-013 In DRAIN, a further PC_SEL SHALL overwrite the pending target.
REQ-014 At completion in DRAIN: discard the data, fetch PC<=pending target (or the new aligned target if PC_SEL=1 that cycle), go to FETCH.
REQ-015 FLUSH_OUT SHALL be 1 for exactly the one cycle following each cycle with PC_SEL=1.
REQ-016 Fetch PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-017 When INSTR_VALID=0, INSTR_OUT SHALL be the NOP 32'h0000_0013.

Reset
REQ-018 RESET_N=0 SHALL asynchronously set state=FETCH, fetch PC=RESET_PC, INSTR_OUT=NOP, PC_OUT=RESET_PC, INSTR_VALID=0, FLUSH_OUT=0, pending target=0, counters=0.
REQ-019 Reset asserted mid-read SHALL abandon the read; after release, fetching SHALL restart at RESET_PC.

Configuration
REQ-020 With macro FETCH_PERF_CNT_EN defined, FETCH_CNT SHALL increment on each delivery per REQ-006 and REDIRECT_CNT on each PC_SEL cycle; both are 32-bit and wrap.
REQ-021 Without FETCH_PERF_CNT_EN, both counter ports SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-022 Package pc_fetch_pkg SHALL hold the FSM state enum, the NOP constant and the default RESET_PC.
REQ-023 The counters SHALL be sub-module fetch_perf_counter, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-024 RESET_PC=0x100, zero-wait memory -> IMEM_ADDR 0x100,0x104,0x108 on consecutive cycles; PC_OUT 0x100 with INSTR_VALID=1 one cycle after the first read.
REQ-025 IMEM_BUSYWAIT=1 for 3 cycles at 0x104 -> IMEM_ADDR held at 0x104 for 4 cycles; exactly one instruction delivered.
REQ-026 PC_SEL=1, target 0x200, while busy at 0x108 -> DRAIN; 0x108 data discarded; next IMEM_ADDR=0x200; one FLUSH_OUT pulse.
REQ-027 STALL=1 for 4 cycles with valid 0x10C held -> HOLD, IMEM_READ=0, PC_OUT held at 0x10C; on release, next delivered PC=0x110 (no skip, no duplicate).
REQ-028 PC_SEL=1 and STALL=1 together in HOLD, target 0x203 -> INSTR_VALID=0 the next cycle and IMEM_ADDR=0x200.
REQ-029 FETCH_PERF_CNT_EN defined, 10 deliveries and 2 redirects -> FETCH_CNT=10, REDIRECT_CNT=2; undefined -> both 0.
